// File: rtl/avg_pkg.sv
// rtl/avg_pkg.sv - shared opcode and action-state encodings for the vector sequencer
package avg_pkg;

  localparam int PC_W_DEFAULT = 13;

  typedef enum logic [2:0] {
    OP_VCTR = 3'd0,
    OP_HALT = 3'd1,
    OP_SVEC = 3'd2,
    OP_STAT = 3'd3,
    OP_CNTR = 3'd4,
    OP_JSRL = 3'd5,
    OP_RTSL = 3'd6,
    OP_JMPL = 3'd7
  } op_e;

  localparam logic [3:0] S_LD0  = 4'd8;
  localparam logic [3:0] S_LD1  = 4'd9;
  localparam logic [3:0] S_LD2  = 4'd10;
  localparam logic [3:0] S_LD3  = 4'd11;
  localparam logic [3:0] S_EXEC = 4'd12;

endpackage

// File: rtl/avg_return_stack.sv
// rtl/avg_return_stack.sv - circular LIFO of subroutine return word-addresses
module avg_return_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 12
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] pop_data
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] sp;
  logic [PW-1:0] top;

  // The pointer simply wraps: overflow overwrites the oldest entry, underflow re-reads it.
  assign top      = sp - PW'(1);
  assign pop_data = mem[top];

  always_ff @(posedge clk) begin
    if (push) mem[sp] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset || clear) sp <= '0;
    else if (push)      sp <= sp + PW'(1);
    else if (pop)       sp <= top;
  end

endmodule

// File: rtl/avg_sequencer.sv
// rtl/avg_sequencer.sv - two-phase PROM-driven sequencer fetching and executing display-list words
module avg_sequencer
  import avg_pkg::*;
#(
  parameter int STACK_DEPTH = 4,
  parameter int PC_W        = PC_W_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            go,
  input  logic            vgrst,
  output logic            halted,
  output logic [PC_W-1:0] vram_addr,
  input  logic [7:0]      vram_data,
  output logic [7:0]      prom_addr,
  input  logic [3:0]      prom_data,
  output logic [31:0]     instr,
  output logic [2:0]      op,
  output logic            draw_start,
  input  logic            draw_busy,
  output logic            stat_ld,
  output logic            cntr
);

  localparam int RA_W = PC_W - 1;

  logic [3:0]      state, state_d;
  logic            phase, phase_d;
  logic            halted_q, halted_d;
  logic [PC_W-1:0] pc, pc_d;
  logic [31:0]     instr_q, instr_d;
  logic            push, pop, stack_clr, exec;
  logic [RA_W-1:0] ret_addr;
  op_e             cur_op;

  assign cur_op    = op_e'(instr_q[15:13]);
  assign op        = instr_q[15:13];
  assign instr     = instr_q;
  assign halted    = halted_q;
  assign vram_addr = pc;
  assign prom_addr = {draw_busy, instr_q[15:13], state};
  assign exec      = !halted_q && phase && (state == S_EXEC);

  avg_return_stack #(
    .DEPTH(STACK_DEPTH),
    .W    (RA_W)
  ) u_stack (
    .clk      (clk),
    .reset    (reset),
    .clear    (stack_clr || vgrst),
    .push     (push),
    .pop      (pop),
    .push_data(pc[PC_W-1:1]),
    .pop_data (ret_addr)
  );

  always_ff @(posedge clk) begin
    if (reset || vgrst) begin
      halted_q <= 1'b1;
      state    <= '0;
      phase    <= 1'b0;
      pc       <= '0;
      instr_q  <= '0;
    end else begin
      halted_q <= halted_d;
      state    <= state_d;
      phase    <= phase_d;
      pc       <= pc_d;
      instr_q  <= instr_d;
    end
  end

  always_comb begin
    halted_d  = halted_q;
    state_d   = state;
    phase_d   = phase;
    pc_d      = pc;
    instr_d   = instr_q;
    stack_clr = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    if (halted_q) begin
      if (go) begin
        halted_d  = 1'b0;
        state_d   = '0;
        phase_d   = 1'b0;
        pc_d      = '0;
        stack_clr = 1'b1;
      end
    end else if (!phase) begin
      phase_d = 1'b1;
    end else begin
      // PROM data was addressed during phase 0, so it is the successor of the current state.
      phase_d = 1'b0;
      state_d = prom_data;
      case (state)
        S_LD0: begin instr_d[7:0]   = vram_data; pc_d = pc + PC_W'(1); end
        S_LD1: begin instr_d[15:8]  = vram_data; pc_d = pc + PC_W'(1); end
        S_LD2: begin instr_d[23:16] = vram_data; pc_d = pc + PC_W'(1); end
        S_LD3: begin instr_d[31:24] = vram_data; pc_d = pc + PC_W'(1); end
        S_EXEC: begin
          case (cur_op)
            OP_HALT: halted_d = 1'b1;
            OP_JSRL: begin push = 1'b1; pc_d = {instr_q[RA_W-1:0], 1'b0}; end
            OP_RTSL: begin pop = 1'b1; pc_d = {ret_addr, 1'b0}; end
            OP_JMPL: pc_d = {instr_q[RA_W-1:0], 1'b0};
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    draw_start = 1'b0;
    stat_ld    = 1'b0;
    cntr       = 1'b0;
    if (exec) begin
      case (cur_op)
        OP_VCTR, OP_SVEC: draw_start = 1'b1;
        OP_STAT:          stat_ld    = 1'b1;
        OP_CNTR:          cntr       = 1'b1;
        default: ;
      endcase
    end
  end

endmodule
